// File: rtl/leaf_stream_fifo.sv
// -----------------------------------------------------------------------------
// leaf_stream_fifo
//   Leaf buffering stage sitting below one child slot of a fan-out node.
//   Synchronous FIFO of DEPTH words with valid/ready handshakes on both
//   sides, an occupancy count and full/empty flags. The head word is read
//   straight out of the storage array at the read pointer, so a word pushed
//   on edge N is presented with out_valid=1 during the following cycle.
//
//   Optional build macro: LEAF_FIFO_STATS_EN
//     When defined, 16-bit wrapping counters of accepted pushes and pops are
//     added as output ports (used for hierarchy-wide traffic checks).
//
// Parameters
//   DATA_W     payload width in bits (>=1)
//   DEPTH      storage entries, power of two, >=2
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   upstream word present
//   in_ready   FIFO accepts a word this cycle (!full & !rst)
//   in_data    upstream payload, sampled only on an accepted push
//   out_valid  head word present (!empty)
//   out_ready  downstream accepts the head word
//   out_data   head payload (don't-care while empty)
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   push_cnt   accepted pushes, wrapping    (LEAF_FIFO_STATS_EN only)
//   pop_cnt    accepted pops, wrapping      (LEAF_FIFO_STATS_EN only)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module leaf_stream_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
`ifdef LEAF_FIFO_STATS_EN
   ,
   output logic [15:0]                push_cnt,
   output logic [15:0]                pop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wp_q, wp_d;
   logic [AW-1:0]     rp_q, rp_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push, pop;

   // Flags come from registered occupancy only. in_ready deliberately ignores
   // out_ready, so a full FIFO refuses a push even in a cycle where it pops.
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign in_ready  = !full && !rst;
   assign out_valid = !empty;
   assign out_data  = mem_q[rp_q];

   assign push = in_valid  && in_ready;
   assign pop  = out_valid && out_ready;

   // Pointers are exactly AW bits wide, so the +1 wraps DEPTH-1 -> 0 for free.
   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (push) begin
         wp_d = wp_q + AW'(1);
      end
      if (pop) begin
         rp_d = rp_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; push already implies !rst through in_ready.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wp_q] <= in_data;
      end
   end

`ifdef LEAF_FIFO_STATS_EN
   logic [15:0] push_cnt_q, push_cnt_d;
   logic [15:0] pop_cnt_q,  pop_cnt_d;

   always_comb begin
      push_cnt_d = push_cnt_q;
      pop_cnt_d  = pop_cnt_q;
      if (push) begin
         push_cnt_d = push_cnt_q + 16'd1;
      end
      if (pop) begin
         pop_cnt_d = pop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         push_cnt_q <= '0;
         pop_cnt_q  <= '0;
      end else begin
         push_cnt_q <= push_cnt_d;
         pop_cnt_q  <= pop_cnt_d;
      end
   end

   assign push_cnt = push_cnt_q;
   assign pop_cnt  = pop_cnt_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
